// File: rtl/button_conditioner_pkg.sv
// ============================================================================
// Module      : button_conditioner_pkg
// Description : Shared reset-FSM encodings, default timing constants and a
//               ceiling-log2 helper for the button conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_POR    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_ACTIVE = 2'd3
  } rst_state_e;

  localparam int unsigned c_DEBOUNCE_DEFAULT = 100000;
  localparam int unsigned c_STRETCH_DEFAULT  = 1000;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int unsigned f_clog2(input int unsigned value);
    int unsigned w;
    longint unsigned v;
    w = 0;
    v = 1;
    while (v < longint'(value)) begin
      v = v << 1;
      w++;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_channel.sv
// ============================================================================
// Module      : button_channel
// Description : One active-low button: two-flop synchroniser, debounce
//               counter, press/release pulses and a sticky press flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_but,
  input  logic i_sticky_clr,
  output logic o_state,
  output logic o_state_nxt,
  output logic o_press,
  output logic o_release,
  output logic o_sticky
);

  localparam int unsigned        c_CW       = f_clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CW-1:0]    c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic [c_CW-1:0] r_cnt;
  logic            r_state;
  logic            r_press;
  logic            r_release;
  logic            r_sticky;

  logic w_raw;
  logic w_diff;
  logic w_flip;

  assign w_raw  = ~r_sync2;
  assign w_diff = w_raw ^ r_state;
  assign w_flip = w_diff && (r_cnt == c_CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_cnt     <= '0;
      r_state   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_sticky  <= 1'b0;
    end else begin
      r_sync1   <= i_but;
      r_sync2   <= r_sync1;
      if (!w_diff || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_state   <= r_state ^ w_flip;
      r_press   <= w_flip & w_raw;
      r_release <= w_flip & ~w_raw;
      // A press arriving with a clear keeps the flag set.
      r_sticky  <= r_press | (r_sticky & ~i_sticky_clr);
    end
  end

  assign o_state     = r_state;
  assign o_state_nxt = r_state ^ w_flip;
  assign o_press     = r_press;
  assign o_release   = r_release;
  assign o_sticky    = r_sticky;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module      : button_conditioner
// Description : Conditions NUM_BUTTONS active-low buttons and generates a
//               stretched, maskable CPU reset request. Optional long-press
//               qualification of the reset via BUTTON_LONGPRESS_RESET_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned            NUM_BUTTONS     = 2,
  parameter int unsigned            DEBOUNCE_CYCLES = c_DEBOUNCE_DEFAULT,
  parameter logic [NUM_BUTTONS-1:0] RESET_MASK      = 2'b11,
  parameter int unsigned            RESET_STRETCH   = c_STRETCH_DEFAULT,
  parameter int unsigned            HOLD_CYCLES     = 200000000
) (
  input  logic                   CLK_100MHz,
  input  logic                   RESET_N,
  input  logic [NUM_BUTTONS-1:0] BUT,
  output logic [NUM_BUTTONS-1:0] BTN_STATE,
  output logic [NUM_BUTTONS-1:0] BTN_PRESS,
  output logic [NUM_BUTTONS-1:0] BTN_RELEASE,
  output logic [NUM_BUTTONS-1:0] BTN_STICKY,
  input  logic [NUM_BUTTONS-1:0] STICKY_CLR,
  output logic                   RESET_REQ
);

  localparam int unsigned     c_SW           = f_clog2(RESET_STRETCH + 1);
  localparam logic [c_SW-1:0] c_STRETCH_LOAD = c_SW'(RESET_STRETCH);
  localparam logic [c_SW-1:0] c_STRETCH_ONE  = c_SW'(1);

  if (NUM_BUTTONS < 1 || NUM_BUTTONS > 16) begin : g_bad_num_buttons
    $error("NUM_BUTTONS must be 1..16");
  end
  if (DEBOUNCE_CYCLES < 1 || RESET_STRETCH < 1 || HOLD_CYCLES < 1) begin : g_bad_timing
    $error("DEBOUNCE_CYCLES, RESET_STRETCH and HOLD_CYCLES must be at least 1");
  end

  logic [NUM_BUTTONS-1:0] w_state_nxt;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_channel
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_channel (
      .i_clk        (CLK_100MHz),
      .i_rst_n      (RESET_N),
      .i_but        (BUT[g]),
      .i_sticky_clr (STICKY_CLR[g]),
      .o_state      (BTN_STATE[g]),
      .o_state_nxt  (w_state_nxt[g]),
      .o_press      (BTN_PRESS[g]),
      .o_release    (BTN_RELEASE[g]),
      .o_sticky     (BTN_STICKY[g])
    );
  end

  // The next debounced level lets RESET_REQ rise on the same edge as BTN_STATE.
  logic w_masked_now;
  logic w_masked_nxt;
  assign w_masked_now = |(BTN_STATE & RESET_MASK);
  assign w_masked_nxt = |(w_state_nxt & RESET_MASK);

  rst_state_e      r_fsm;
  rst_state_e      w_fsm_nxt;
  logic [c_SW-1:0] r_stretch;
  logic [c_SW-1:0] w_stretch_nxt;
  logic            w_req;

`ifdef BUTTON_LONGPRESS_RESET_EN
  localparam int unsigned     c_HW        = f_clog2(HOLD_CYCLES + 1);
  localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD_CYCLES - 1);
  logic [c_HW-1:0] r_hold;
  logic [c_HW-1:0] w_hold_nxt;
`endif

  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      r_fsm     <= ST_POR;
      r_stretch <= c_STRETCH_LOAD;
`ifdef BUTTON_LONGPRESS_RESET_EN
      r_hold    <= '0;
`endif
    end else begin
      r_fsm     <= w_fsm_nxt;
      r_stretch <= w_stretch_nxt;
`ifdef BUTTON_LONGPRESS_RESET_EN
      r_hold    <= w_hold_nxt;
`endif
    end
  end

  always_comb begin
    w_fsm_nxt     = r_fsm;
    w_stretch_nxt = r_stretch;
    w_req         = 1'b1;
`ifdef BUTTON_LONGPRESS_RESET_EN
    w_hold_nxt    = r_hold;
`endif
    case (r_fsm)
      ST_POR: begin
        if (r_stretch <= c_STRETCH_ONE) begin
          w_fsm_nxt     = ST_IDLE;
          w_stretch_nxt = '0;
        end else begin
          w_stretch_nxt = r_stretch - 1'b1;
        end
      end
      ST_IDLE: begin
        w_req = 1'b0;
        if (w_masked_nxt) begin
`ifdef BUTTON_LONGPRESS_RESET_EN
          w_fsm_nxt     = ST_HOLD;
          w_hold_nxt    = '0;
`else
          w_fsm_nxt     = ST_ACTIVE;
          w_stretch_nxt = c_STRETCH_LOAD;
`endif
        end
      end
`ifdef BUTTON_LONGPRESS_RESET_EN
      ST_HOLD: begin
        w_req = 1'b0;
        if (!w_masked_nxt) begin
          w_fsm_nxt  = ST_IDLE;
          w_hold_nxt = '0;
        end else if (r_hold == c_HOLD_LAST) begin
          w_fsm_nxt     = ST_ACTIVE;
          w_stretch_nxt = c_STRETCH_LOAD;
          w_hold_nxt    = '0;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
`endif
      ST_ACTIVE: begin
        if (w_masked_now || w_masked_nxt) begin
          w_stretch_nxt = c_STRETCH_LOAD;
        end else if (r_stretch <= c_STRETCH_ONE) begin
          w_fsm_nxt     = ST_IDLE;
          w_stretch_nxt = '0;
        end else begin
          w_stretch_nxt = r_stretch - 1'b1;
        end
      end
      default: begin
        w_req     = 1'b0;
        w_fsm_nxt = ST_IDLE;
      end
    endcase
  end

  assign RESET_REQ = w_req;

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed self-checking bench for button_conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] but;
  logic [1:0] clr;
  logic [1:0] state;
  logic [1:0] press;
  logic [1:0] rel;
  logic [1:0] sticky;
  logic       req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BUTTONS     (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_MASK      (2'b01),
    .RESET_STRETCH   (8),
    .HOLD_CYCLES     (16)
  ) dut (
    .CLK_100MHz  (clk),
    .RESET_N     (rst_n),
    .BUT         (but),
    .BTN_STATE   (state),
    .BTN_PRESS   (press),
    .BTN_RELEASE (rel),
    .BTN_STICKY  (sticky),
    .STICKY_CLR  (clr),
    .RESET_REQ   (req)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_por(input string name);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (req !== 1'(k < 8)) begin
        errors++;
        $display("FAIL %s cycle %0d req=%b exp=%b", name, k, req, 1'(k < 8));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    but   = 2'b11;
    clr   = 2'b00;
    repeat (3) tick();
    checks++;
    if (req !== 1'b1 || state !== 2'b00 || press !== 2'b00 || rel !== 2'b00 || sticky !== 2'b00) begin
      errors++;
      $display("FAIL reset_values req=%b state=%b press=%b rel=%b sticky=%b exp 1/00/00/00/00",
               req, state, press, rel, sticky);
    end
    #2 rst_n = 1'b1;
    check_por("por_stretch");
    checks++;
    if (state !== 2'b00 || press !== 2'b00 || rel !== 2'b00 || sticky !== 2'b00) begin
      errors++;
      $display("FAIL post_por_outputs state=%b press=%b rel=%b sticky=%b exp all 00",
               state, press, rel, sticky);
    end
  endtask

  task automatic test_unmasked_press();
    but[1] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) begin
        checks++;
        if (state !== 2'b00) begin
          errors++;
          $display("FAIL unmasked_early state=%b exp=00", state);
        end
      end
    end
    checks++;
    if (state !== 2'b10 || press !== 2'b10 || req !== 1'b0) begin
      errors++;
      $display("FAIL unmasked_press state=%b press=%b req=%b exp 10/10/0", state, press, req);
    end
    tick();
    checks++;
    if (press !== 2'b00 || sticky !== 2'b10 || req !== 1'b0) begin
      errors++;
      $display("FAIL unmasked_pulse_end press=%b sticky=%b req=%b exp 00/10/0", press, sticky, req);
    end
    but[1] = 1'b1;
    repeat (6) tick();
    checks++;
    if (state !== 2'b00 || rel !== 2'b10) begin
      errors++;
      $display("FAIL unmasked_release state=%b rel=%b exp 00/10", state, rel);
    end
    tick();
    checks++;
    if (rel !== 2'b00 || sticky !== 2'b10) begin
      errors++;
      $display("FAIL release_pulse_end rel=%b sticky=%b exp 00/10", rel, sticky);
    end
  endtask

  task automatic test_glitch();
    but[0] = 1'b0;
    repeat (3) tick();
    but[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (state !== 2'b00 || press !== 2'b00 || req !== 1'b0) begin
        errors++;
        $display("FAIL glitch cycle %0d state=%b press=%b req=%b exp 00/00/0", k, state, press, req);
      end
    end
  endtask

  task automatic test_masked_reset();
    but[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) begin
        checks++;
        if (state !== 2'b00 || req !== 1'b0) begin
          errors++;
          $display("FAIL masked_early state=%b req=%b exp 00/0", state, req);
        end
      end
    end
    checks++;
    if (state !== 2'b01 || press !== 2'b01 || req !== 1'b1) begin
      errors++;
      $display("FAIL masked_rise state=%b press=%b req=%b exp 01/01/1", state, press, req);
    end
    for (int k = 1; k <= 14; k++) begin
      tick();
      checks++;
      if (req !== 1'b1) begin
        errors++;
        $display("FAIL masked_held cycle %0d req=%b exp=1", k, req);
      end
    end
    but[0] = 1'b1;
    repeat (6) tick();
    checks++;
    if (state !== 2'b00 || rel !== 2'b01 || req !== 1'b1) begin
      errors++;
      $display("FAIL masked_fall state=%b rel=%b req=%b exp 00/01/1", state, rel, req);
    end
    // Re-press so the debounced rise lands while the stretch counter is at 3.
    but[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (req !== 1'b1) begin
        errors++;
        $display("FAIL repress_extend cycle %0d req=%b exp=1", k, req);
      end
      if (k == 6) begin
        checks++;
        if (state !== 2'b01) begin
          errors++;
          $display("FAIL repress_state state=%b exp=01", state);
        end
      end
    end
    but[0] = 1'b1;
    repeat (6) tick();
    checks++;
    if (state !== 2'b00 || req !== 1'b1) begin
      errors++;
      $display("FAIL second_fall state=%b req=%b exp 00/1", state, req);
    end
    check_por("release_stretch");
  endtask

  task automatic test_sticky_clear();
    clr = 2'b10;
    tick();
    clr = 2'b00;
    checks++;
    if (sticky[1] !== 1'b0) begin
      errors++;
      $display("FAIL sticky_lone_clear sticky1=%b exp=0", sticky[1]);
    end
    clr = 2'b10;
    tick();
    clr = 2'b00;
    checks++;
    if (sticky[1] !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear_idle sticky1=%b exp=0", sticky[1]);
    end
    but[1] = 1'b0;
    repeat (6) tick();
    checks++;
    if (press !== 2'b10) begin
      errors++;
      $display("FAIL sticky_press press=%b exp=10", press);
    end
    clr = 2'b10;
    tick();
    clr = 2'b00;
    checks++;
    if (sticky[1] !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set_wins sticky1=%b exp=1", sticky[1]);
    end
    tick();
    checks++;
    if (sticky[1] !== 1'b1) begin
      errors++;
      $display("FAIL sticky_hold sticky1=%b exp=1", sticky[1]);
    end
    clr = 2'b10;
    tick();
    clr = 2'b00;
    checks++;
    if (sticky[1] !== 1'b0 || req !== 1'b0) begin
      errors++;
      $display("FAIL sticky_later_clear sticky1=%b req=%b exp 0/0", sticky[1], req);
    end
    but[1] = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_async_reset();
    but[0] = 1'b0;
    repeat (6) tick();
    checks++;
    if (req !== 1'b1 || state[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_async req=%b state0=%b exp 1/1", req, state[0]);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'b00 || press !== 2'b00 || sticky !== 2'b00 || req !== 1'b1) begin
      errors++;
      $display("FAIL async_reset state=%b press=%b sticky=%b req=%b exp 00/00/00/1",
               state, press, sticky, req);
    end
    but = 2'b11;
    repeat (2) tick();
    #2 rst_n = 1'b1;
    check_por("async_por_stretch");
  endtask

`ifdef BUTTON_LONGPRESS_RESET_EN
  task automatic test_longpress();
    but[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10) but[0] = 1'b1;
      checks++;
      if (req !== 1'b0) begin
        errors++;
        $display("FAIL short_press cycle %0d req=%b exp=0", k, req);
      end
      if (k == 6) begin
        checks++;
        if (press !== 2'b01) begin
          errors++;
          $display("FAIL short_press_pulse press=%b exp=01", press);
        end
      end
    end
    but[0] = 1'b0;
    repeat (21) tick();
    checks++;
    if (req !== 1'b0 || state[0] !== 1'b1) begin
      errors++;
      $display("FAIL hold_not_yet req=%b state0=%b exp 0/1", req, state[0]);
    end
    tick();
    checks++;
    if (req !== 1'b1) begin
      errors++;
      $display("FAIL hold_reached req=%b exp=1", req);
    end
    but[0] = 1'b1;
    repeat (6) tick();
    check_por("long_release_stretch");
    but[0] = 1'b0;
    repeat (10) tick();
    checks++;
    if (req !== 1'b0 || state[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_hold req=%b state0=%b exp 0/1", req, state[0]);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'b00 || sticky !== 2'b00 || req !== 1'b1) begin
      errors++;
      $display("FAIL hold_async_reset state=%b sticky=%b req=%b exp 00/00/1", state, sticky, req);
    end
    but = 2'b11;
    repeat (2) tick();
    #2 rst_n = 1'b1;
    check_por("hold_por_stretch");
  endtask
`endif

  initial begin
    test_reset();
    test_unmasked_press();
    test_glitch();
`ifndef BUTTON_LONGPRESS_RESET_EN
    test_masked_reset();
`endif
    test_sticky_clear();
`ifdef BUTTON_LONGPRESS_RESET_EN
    test_longpress();
`else
    test_async_reset();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
